// File: rtl/hud_pkg.sv
// Shared types and constants for the HUD digit renderer.
// Glyph ROM geometry and key colour are fixed by the ROM contents.
package hud_pkg;

    typedef logic [9:0] color_idx_t;

    localparam color_idx_t KEY_COLOR = 10'd391;
    localparam int GW = 32;
    localparam int GH = 24;

    typedef enum logic [1:0] {
        SHOW      = 2'd0,
        BLINK_ON  = 2'd1,
        BLINK_OFF = 2'd2
    } blink_state_t;

    function automatic logic [3:0] clamp_digit(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

endpackage

// File: rtl/blink_fsm.sv
// Frame-synchronous blink-on-change sequencer for the HUD digit.
// state      | meaning
// SHOW       | steady display, digit visible
// BLINK_OFF  | blink half-phase with digit hidden
// BLINK_ON   | blink half-phase with digit shown
module blink_fsm
    import hud_pkg::*;
#(
    parameter int BLINK_PERIOD  = 8,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_start,
    input  logic load_new,
    output logic visible
);

    localparam int FW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam int TW = $clog2(BLINK_TOGGLES + 1);

    blink_state_t   state, state_nxt;
    logic [FW-1:0]  frame_cnt, frame_nxt;
    logic [TW-1:0]  tog_cnt, tog_nxt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= SHOW;
            frame_cnt <= '0;
            tog_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            frame_cnt <= frame_nxt;
            tog_cnt   <= tog_nxt;
        end
    end

    // A differing value always wins and restarts the burst hidden.
    always_comb begin
        state_nxt = state;
        frame_nxt = frame_cnt;
        tog_nxt   = tog_cnt;
        if (frame_start) begin
            if (load_new) begin
                state_nxt = BLINK_OFF;
                frame_nxt = '0;
                tog_nxt   = '0;
            end else if (state != SHOW) begin
                if (frame_cnt == FW'(BLINK_PERIOD - 1)) begin
                    frame_nxt = '0;
                    tog_nxt   = tog_cnt + 1'b1;
                    if (tog_cnt == TW'(BLINK_TOGGLES - 1)) begin
                        state_nxt = SHOW;
                    end else if (state == BLINK_OFF) begin
                        state_nxt = BLINK_ON;
                    end else begin
                        state_nxt = BLINK_OFF;
                    end
                end else begin
                    frame_nxt = frame_cnt + 1'b1;
                end
            end
        end
    end

    assign visible = (state != BLINK_OFF);

endmodule

// File: rtl/digit_sprite_renderer.sv
// Draws one HUD digit from the glyph ROMs at a fixed screen position.
// Two-stage pipeline: box test/ROM address, then key-colour transparency.
module digit_sprite_renderer
    import hud_pkg::*;
#(
    parameter logic [9:0] X0            = 10'd560,
    parameter logic [9:0] Y0            = 10'd16,
    parameter int         BLINK_PERIOD  = 8,
    parameter int         BLINK_TOGGLES = 6
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_start,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       pix_en,
    input  logic [3:0] value_in,
    input  logic       value_load,
    output logic [3:0] glyph_sel,
    output logic [4:0] glyph_row,
    output logic [4:0] glyph_col,
    input  color_idx_t glyph_rgb,
    output logic       pix_hit,
    output color_idx_t pix_rgb
);

    logic [3:0] shown;
    logic [3:0] pending;
    logic       pend_vld;
    logic       load_new;
    logic       visible;
    logic       in_box;
    logic       s1_vld;

    assign load_new = frame_start & pend_vld & (pending != shown);

    // shown only moves on frame_start so a digit never tears mid-frame;
    // a load coinciding with frame_start waits for the following frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shown    <= '0;
            pending  <= '0;
            pend_vld <= 1'b0;
        end else begin
            if (load_new) begin
                shown <= pending;
            end
            if (value_load) begin
                pending  <= clamp_digit(value_in);
                pend_vld <= 1'b1;
            end else if (frame_start) begin
                pend_vld <= 1'b0;
            end
        end
    end

    blink_fsm #(
        .BLINK_PERIOD  (BLINK_PERIOD),
        .BLINK_TOGGLES (BLINK_TOGGLES)
    ) u_blink (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .load_new    (load_new),
        .visible     (visible)
    );

    assign in_box = pix_en
                  & (DrawX >= X0) & (DrawX < X0 + 10'(GW))
                  & (DrawY >= Y0) & (DrawY < Y0 + 10'(GH));

    // Outside the box the ROM address holds, keeping the mux input quiet.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_vld    <= 1'b0;
            glyph_sel <= '0;
            glyph_row <= '0;
            glyph_col <= '0;
        end else begin
            s1_vld <= in_box & visible;
            if (in_box) begin
                glyph_sel <= shown;
                glyph_row <= 5'(DrawY - Y0);
                glyph_col <= 5'(DrawX - X0);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_hit <= 1'b0;
            pix_rgb <= '0;
        end else begin
            pix_hit <= s1_vld & (glyph_rgb != KEY_COLOR);
            pix_rgb <= (s1_vld & (glyph_rgb != KEY_COLOR)) ? glyph_rgb : '0;
        end
    end

endmodule

// File: tb/tb_digit_sprite_renderer.sv
// Directed bench for digit_sprite_renderer with a synthetic glyph ROM.
module tb_digit_sprite_renderer;
    import hud_pkg::*;

    localparam logic [9:0] X0 = 10'd560;
    localparam logic [9:0] Y0 = 10'd16;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_start;
    logic [9:0] DrawX, DrawY;
    logic       pix_en;
    logic [3:0] value_in;
    logic       value_load;
    logic [3:0] glyph_sel;
    logic [4:0] glyph_row, glyph_col;
    color_idx_t glyph_rgb;
    logic       pix_hit;
    color_idx_t pix_rgb;

    int vectors = 0;
    int miscompares = 0;
    int rom_mode = 0;

    logic       p_hit;
    logic [9:0] p_rgb;
    logic [4:0] p_row, p_col;
    logic [3:0] p_sel;

    digit_sprite_renderer dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .pix_en      (pix_en),
        .value_in    (value_in),
        .value_load  (value_load),
        .glyph_sel   (glyph_sel),
        .glyph_row   (glyph_row),
        .glyph_col   (glyph_col),
        .glyph_rgb   (glyph_rgb),
        .pix_hit     (pix_hit),
        .pix_rgb     (pix_rgb)
    );

    always #5 Clk = ~Clk;

    // Normal ROM content is {0,sel,col}, never equal to the key colour.
    assign glyph_rgb = (rom_mode == 1) ? 10'd391 :
                       (rom_mode == 2) ? 10'd430 : {1'b0, glyph_sel, glyph_col};

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
    endtask

    task automatic load(input logic [3:0] v);
        value_in   = v;
        value_load = 1'b1;
        tick();
        value_load = 1'b0;
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic en);
        DrawX  = x;
        DrawY  = y;
        pix_en = en;
        tick();
        p_sel  = glyph_sel;
        p_row  = glyph_row;
        p_col  = glyph_col;
        pix_en = 1'b0;
        tick();
        p_hit  = pix_hit;
        p_rgb  = pix_rgb;
    endtask

    initial begin
        Reset_n = 1'b0; frame_start = 1'b0; DrawX = '0; DrawY = '0;
        pix_en = 1'b0; value_in = '0; value_load = 1'b0;
        repeat (3) tick();
        chk("rst_hit", pix_hit, 0);
        chk("rst_rgb", pix_rgb, 0);
        chk("rst_sel", glyph_sel, 0);
        chk("rst_row", glyph_row, 0);
        chk("rst_col", glyph_col, 0);
        Reset_n = 1'b1;
        tick();

        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("show0_row", p_row, 4);
        chk("show0_col", p_col, 5);
        chk("show0_hit", p_hit, 1);
        chk("show0_rgb", p_rgb, 5);

        load(4'd3);
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("midframe_sel", p_sel, 0);
        chk("midframe_rgb", p_rgb, 5);
        frames(1);
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("blink_sel", p_sel, 3);
        chk("blink_off0", p_hit, 0);
        chk("blink_off0_rgb", p_rgb, 0);
        frames(7);
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("blink_off7", p_hit, 0);
        frames(1);
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("blink_on8", p_hit, 1);
        chk("blink_on8_rgb", p_rgb, 101);
        frames(8);
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("blink_off16", p_hit, 0);
        frames(31);
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("blink_on47", p_hit, 1);
        frames(1);
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("show48", p_hit, 1);
        frames(8);
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("show56", p_hit, 1);

        rom_mode = 1;
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("key_hit", p_hit, 0);
        chk("key_rgb", p_rgb, 0);
        rom_mode = 2;
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("c430_hit", p_hit, 1);
        chk("c430_rgb", p_rgb, 430);
        rom_mode = 0;

        probe(X0 + 10'd31, Y0, 1'b1);
        chk("xlast_hit", p_hit, 1);
        chk("xlast_col", p_col, 31);
        chk("xlast_row", p_row, 0);
        chk("xlast_rgb", p_rgb, 127);
        probe(X0 + 10'd32, Y0, 1'b1);
        chk("xout_hit", p_hit, 0);
        chk("xout_colhold", p_col, 31);
        probe(X0 + 10'd5, Y0 - 10'd1, 1'b1);
        chk("yabove_hit", p_hit, 0);
        probe(X0, Y0 + 10'd23, 1'b1);
        chk("ylast_hit", p_hit, 1);
        chk("ylast_row", p_row, 23);
        chk("ylast_rgb", p_rgb, 96);
        probe(X0, Y0 + 10'd24, 1'b1);
        chk("yout_hit", p_hit, 0);
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b0);
        chk("en0_hit", p_hit, 0);
        chk("en0_rowhold", p_row, 23);

        load(4'd12);
        frames(1);
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("clamp_sel", p_sel, 9);
        chk("clamp_blink", p_hit, 0);
        frames(48);
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("nine_show", p_rgb, 293);
        load(4'd9);
        frames(1);
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("same_noblink", p_hit, 1);
        chk("same_rgb", p_rgb, 293);

        load(4'd5);
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("load5_mid_sel", p_sel, 9);
        chk("load5_mid_hit", p_hit, 1);
        frames(1);
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("load5_sel", p_sel, 5);
        chk("load5_blink", p_hit, 0);

        value_in = 4'd7; value_load = 1'b1; frame_start = 1'b1;
        tick();
        value_load = 1'b0; frame_start = 1'b0;
        tick();
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("coinc_sel", p_sel, 5);
        frames(1);
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("coinc_next_sel", p_sel, 7);
        frames(7);
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("restart_off7", p_hit, 0);
        frames(1);

        DrawX = X0 + 10'd5; DrawY = Y0 + 10'd4; pix_en = 1'b1;
        tick();
        tick();
        chk("pre_rst_hit", pix_hit, 1);
        chk("pre_rst_rgb", pix_rgb, 229);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_hit", pix_hit, 0);
        chk("arst_rgb", pix_rgb, 0);
        chk("arst_sel", glyph_sel, 0);
        chk("arst_row", glyph_row, 0);
        chk("arst_col", glyph_col, 0);
        pix_en = 1'b0;
        tick();
        Reset_n = 1'b1;
        probe(X0 + 10'd5, Y0 + 10'd4, 1'b1);
        chk("post_rst_hit", p_hit, 1);
        chk("post_rst_rgb", p_rgb, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
